// File: rtl/bsg_popcount_stream_acc.sv
// ============================================================================
// bsg_popcount_stream_acc
// ----------------------------------------------------------------------------
// Streaming, pipelined population counter with a per-packet accumulator.
// One width_p-bit word per cycle is accepted on a valid/ready handshake. Each
// word comes back stages_p cycles later with its popcount, plus a saturating
// running sum over the packet it belongs to (packets are delimited by last_i).
// Intended to sit between a bit-vector producer (mask/match unit) and a
// consumer that wants per-word and per-packet set-bit totals.
//
// Parameters
//   width_p      input word width (>= 1)
//   stages_p     register stages from accept to v_o (>= 1)
//   acc_width_p  packet sum width (>= $clog2(width_p+1))
//
// Ports
//   clk_i      clock, rising edge
//   reset_n_i  asynchronous, active-low reset
//   v_i        input word valid
//   data_i     input word
//   last_i     input word is the final beat of its packet
//   ready_o    block accepts a word this cycle (combinational from ready_i)
//   v_o        output beat valid
//   count_o    popcount of the word
//   sum_o      saturated packet sum including this word
//   last_o     this beat closes its packet
//   sat_o      packet sum has saturated (sticky up to and including last_o)
//   ready_i    consumer accepts the output beat
// ============================================================================
module bsg_popcount_stream_acc #(
    parameter int width_p     = 16,
    parameter int stages_p    = 2,
    parameter int acc_width_p = 16
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         v_i,
    input  logic [width_p-1:0]           data_i,
    input  logic                         last_i,
    output logic                         ready_o,
    output logic                         v_o,
    output logic [$clog2(width_p+1)-1:0] count_o,
    output logic [acc_width_p-1:0]       sum_o,
    output logic                         last_o,
    output logic                         sat_o,
    input  logic                         ready_i
);

    localparam int count_width_lp = $clog2(width_p + 1);

    // Exact popcount of a full-width word; the result can never exceed
    // width_p, so count_width_lp bits are always enough.
    function automatic logic [count_width_lp-1:0] popcount(input logic [width_p-1:0] word);
        logic [count_width_lp-1:0] total;
        total = '0;
        for (int i = 0; i < width_p; i++) begin
            total = total + count_width_lp'(word[i]);
        end
        return total;
    endfunction

    // Bits of the word owned by a given pipeline slice. Bit i belongs to
    // slice floor(i*stages_p/width_p), so slice sizes differ by at most one
    // bit. When width_p < stages_p some slices are empty and add zero.
    function automatic logic [width_p-1:0] slice_mask(input int slice);
        logic [width_p-1:0] mask;
        mask = '0;
        for (int i = 0; i < width_p; i++) begin
            mask[i] = (((i * stages_p) / width_p) == slice);
        end
        return mask;
    endfunction

    // One global enable: everything advances when the output register is
    // empty or being drained. Bubbles are deliberately not collapsed.
    logic en;

    assign en      = ready_i | ~v_o;
    assign ready_o = en;

    // Beat presented to the output register (last slice already added).
    logic                      out_v;
    logic                      out_last;
    logic [count_width_lp-1:0] out_cnt;

    if (stages_p == 1) begin : g_direct

        // With a single stage the output register is the only register, so
        // the whole word is counted in one slice straight from the input.
        assign out_v    = v_i;
        assign out_last = last_i;
        assign out_cnt  = popcount(data_i & slice_mask(0));

    end else begin : g_pipe

        // Stages 0 .. stages_p-2 each add their slice of the word to the
        // partial count; the word travels along so later slices can see it.
        for (genvar s = 0; s < stages_p - 1; s++) begin : g_stage
            logic                      v_in;
            logic                      last_in;
            logic [width_p-1:0]        data_in;
            logic [count_width_lp-1:0] cnt_in;
            logic                      v_r;
            logic                      last_r;
            logic [width_p-1:0]        data_r;
            logic [count_width_lp-1:0] cnt_r;

            if (s == 0) begin : g_head
                assign v_in    = v_i;
                assign last_in = last_i;
                assign data_in = data_i;
                assign cnt_in  = '0;
            end else begin : g_link
                assign v_in    = g_stage[s-1].v_r;
                assign last_in = g_stage[s-1].last_r;
                assign data_in = g_stage[s-1].data_r;
                assign cnt_in  = g_stage[s-1].cnt_r;
            end

            // Payload only loads alongside a valid beat so that idle or
            // undriven inputs never leak X into the registers.
            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    v_r    <= 1'b0;
                    last_r <= 1'b0;
                    data_r <= '0;
                    cnt_r  <= '0;
                end else if (en) begin
                    v_r <= v_in;
                    if (v_in) begin
                        last_r <= last_in;
                        data_r <= data_in;
                        cnt_r  <= cnt_in + popcount(data_in & slice_mask(s));
                    end
                end
            end
        end

        // The final slice is added on the way into the output register.
        assign out_v    = g_stage[stages_p-2].v_r;
        assign out_last = g_stage[stages_p-2].last_r;
        assign out_cnt  = g_stage[stages_p-2].cnt_r
                        + popcount(g_stage[stages_p-2].data_r & slice_mask(stages_p - 1));

    end

    // Packet accumulator. sum_o doubles as the running accumulator, and
    // start_r marks that the next beat opens a new packet.
    logic                   start_r;
    logic [acc_width_p:0]   acc_base;
    logic [acc_width_p:0]   sum_wide;
    logic                   overflow;
    logic [acc_width_p-1:0] sum_next;
    logic                   sat_next;

    // One spare bit catches the carry out; once set the sum clamps to all
    // ones and the packet is flagged saturated until its last beat.
    always_comb begin
        acc_base = '0;
        if (!start_r) begin
            acc_base = {1'b0, sum_o};
        end
        sum_wide = acc_base + {{(acc_width_p + 1 - count_width_lp){1'b0}}, out_cnt};
        overflow = sum_wide[acc_width_p];
        sum_next = overflow ? '1 : sum_wide[acc_width_p-1:0];
        sat_next = (~start_r & sat_o) | overflow;
    end

    // Output register. The accumulator steps exactly once per beat loaded
    // here, so a held beat (v_o & ~ready_i) keeps every output stable.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_o     <= 1'b0;
            count_o <= '0;
            sum_o   <= '0;
            last_o  <= 1'b0;
            sat_o   <= 1'b0;
            start_r <= 1'b1;
        end else if (en) begin
            v_o <= out_v;
            if (out_v) begin
                count_o <= out_cnt;
                sum_o   <= sum_next;
                last_o  <= out_last;
                sat_o   <= sat_next;
                start_r <= out_last;
            end
        end
    end

endmodule
